encoder_16_4: RTL and testbench
===============================

ENCODER_16_4 -- requirements
Module: encoder_16_4

Interface
Parameters: none; all widths are fixed.
- REQ-001: clk  input  1 -- the single clock; all state updates SHALL occur on the rising edge of clk.
- REQ-002: rst  input  1 -- reset, synchronous and active-high; it SHALL be sampled only on the rising clk edge.
- REQ-003: en  input  1 -- capture enable; when high, the input SHALL be encoded and registered.
- REQ-004: a  input  16, indexed [0:15] -- request vector, bit 0 is the MSB (0x8000 = bit 0, 0x0001 = bit 15).
- REQ-005: y  output  4, indexed [0:3] -- registered index of the winning set bit of a; y[0] is the MSB.
- REQ-006: valid  output  1 -- registered; high when the captured a had at least one bit set.
- REQ-007: multi  output  1 -- registered; high when the captured a had two or more bits set.

Function
- REQ-008: Bit index SHALL follow the [0:15] numbering, so a set bit at index k encodes to y = k (0..15).
- REQ-009: Priority: when several bits are set, y SHALL equal the lowest index, i.e. the set bit nearest the MSB end.
- REQ-010: All-zero input: y SHALL be 0, valid 0 and multi 0.
- REQ-011: One-hot input: y = index, valid 1, multi 0.
- REQ-012: Two or more bits set: y = lowest set index, valid 1, multi 1.
- REQ-013: Latency: outputs SHALL reflect a sampled at rising edge N, visible after edge N, for a fixed latency of 1 cycle; a new input SHALL be accepted every cycle.
- REQ-014: When en = 0 at an edge, y, valid and multi SHALL hold their previous values.
- REQ-015: Outputs SHALL be driven directly from flops, with no combinational path from a or en to any output.
- REQ-016: Every a value SHALL produce a defined output; there SHALL be no X propagation for any 16-bit input.
- REQ-017: The encode logic SHALL be a pure function of a; no history other than the output registers SHALL be kept.

Reset
- REQ-018: When rst = 1 at a rising edge, y SHALL become 0, valid 0 and multi 0, regardless of en and a.
- REQ-019: rst SHALL take priority over en.
- REQ-020: On the first edge with rst = 0 and en = 1, the normal encode SHALL resume with no extra recovery cycle.
- REQ-021: Reset asserted mid-stream SHALL discard the pending input; nothing SHALL be replayed after reset.

Verification
- REQ-022: One-hot sweep, en = 1, a = 0x8000, 0x4000, ... 0x0001, one per cycle -> y = 0, 1, ... 15 one cycle later; valid = 1 and multi = 0 throughout.
- REQ-023: Zero input: a = 0x0000 -> y = 0, valid = 0, multi = 0.
- REQ-024: Priority cases:
  - a = 0x0101 -> y = 7, valid = 1, multi = 1.
  - a = 0xFFFF -> y = 0, multi = 1.
  - a = 0x0003 -> y = 14, multi = 1.
- REQ-025: Enable hold: capture a = 0x0800 (y = 4), then set en = 0 and a = 0x0001 for 3 cycles -> y remains 4 and valid remains 1.
- REQ-026: Reset mid-stream: while y = 9, assert rst for 1 cycle with en = 1 and a = 0x0002 -> after that edge y = 0, valid = 0, multi = 0; the next edge with rst = 0 -> y = 14.
- REQ-027: Exhaustive check: all 65536 values of a SHALL be compared against a reference model of REQ-008 to REQ-012 with the 1-cycle latency applied.

Source files
------------

// File: rtl/encoder_16_4.sv
// Registered 16-to-4 priority encoder; index 0 is the MSB end and wins.
// Also flags whether any bit, or more than one bit, was set.
module encoder_16_4 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [0:15] a,
   output logic [0:3]  y,
   output logic        valid,
   output logic        multi
);

   logic [0:3]  idx;
   logic        any_set;
   logic        many_set;
   logic [0:15] a_dec;

   // Scan from the LSB end upward so the lowest set index overwrites last.
   always_comb begin
      idx = '0;
      for (int k = 15; k >= 0; k--) begin
         if (a[k]) idx = 4'(k);
      end
   end

   assign a_dec    = a - 16'd1;
   assign any_set  = |a;
   assign many_set = |(a & a_dec);

   always_ff @(posedge clk) begin
      if (rst) begin
         y     <= '0;
         valid <= 1'b0;
         multi <= 1'b0;
      end else if (en) begin
         y     <= idx;
         valid <= any_set;
         multi <= many_set;
      end
   end

endmodule

// File: tb/tb_encoder_16_4.sv
// Bench for encoder_16_4: arithmetic reference model checked every cycle,
// directed literal cases, an exhaustive sweep and a random phase.
module tb_encoder_16_4;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [0:15] a;
   logic [0:3]  y;
   logic        valid;
   logic        multi;

   int ncmp = 0;
   int nerr = 0;

   logic [3:0] ey;
   logic       ev;
   logic       em;
   bit         known = 1'b0;

   encoder_16_4 dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .a    (a),
      .y    (y),
      .valid(valid),
      .multi(multi)
   );

   always #5 clk = ~clk;

   // Winning index from the numeric value: bit 0 is weight 2^15.
   function automatic logic [3:0] ref_y(input logic [15:0] v);
      if (v == 16'd0) return 4'd0;
      return 4'(16 - $clog2(32'(v) + 1));
   endfunction

   always @(posedge clk) begin
      if (rst === 1'b1) begin
         ey    = 4'd0;
         ev    = 1'b0;
         em    = 1'b0;
         known = 1'b1;
      end else if (en === 1'b1) begin
         ey = ref_y(a);
         ev = $countones(a) >= 1;
         em = $countones(a) >= 2;
      end
      #1;
      if (known) begin
         ncmp++;
         if (y !== ey || valid !== ev || multi !== em) begin
            nerr++;
            $display("FAIL model a=%h: got y=%0d v=%b m=%b want y=%0d v=%b m=%b",
                     a, y, valid, multi, ey, ev, em);
         end
      end
   end

   task automatic step(input logic r, input logic e, input logic [15:0] v);
      @(negedge clk);
      rst = r;
      en  = e;
      a   = v;
      @(posedge clk);
      #2;
   endtask

   task automatic lit(input string nm, input int wy, input logic wv,
                      input logic wm);
      ncmp++;
      if (y !== 4'(wy) || valid !== wv || multi !== wm) begin
         nerr++;
         $display("FAIL %s: got y=%0d v=%b m=%b want y=%0d v=%b m=%b",
                  nm, y, valid, multi, wy, wv, wm);
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      a   = 16'hFFFF;
      step(1'b1, 1'b1, 16'hFFFF);
      step(1'b1, 1'b0, 16'h1234);
      lit("reset", 0, 1'b0, 1'b0);

      for (int k = 0; k < 16; k++) begin
         step(1'b0, 1'b1, 16'h8000 >> k);
         lit("onehot", k, 1'b1, 1'b0);
      end

      step(1'b0, 1'b1, 16'h0000);
      lit("zero", 0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'h0101);
      lit("pri_0101", 7, 1'b1, 1'b1);
      step(1'b0, 1'b1, 16'hFFFF);
      lit("pri_ffff", 0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 16'h0003);
      lit("pri_0003", 14, 1'b1, 1'b1);

      step(1'b0, 1'b1, 16'h0800);
      lit("hold_cap", 4, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 16'h0001);
         lit("hold", 4, 1'b1, 1'b0);
      end

      step(1'b0, 1'b1, 16'h0040);
      lit("pre_rst", 9, 1'b1, 1'b0);
      step(1'b1, 1'b1, 16'h0002);
      lit("mid_rst", 0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'h0002);
      lit("post_rst", 14, 1'b1, 1'b0);

      for (int v = 0; v < 65536; v++) begin
         step(1'b0, 1'b1, 16'(v));
      end

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
              16'($urandom) & 16'($urandom));
      end

      step(1'b0, 1'b0, 16'h0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
